// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI master transfer controller generating SCLK, active-low CS and
// per-bit shift/sample strobes for one WIDTH-bit frame per start request.
module spi_master_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_cpol,
  input  logic                 i_cpha,
  input  logic [DIV_WIDTH-1:0] i_clk_div,
  output logic                 o_sclk,
  output logic                 o_cs_n,
  output logic                 o_ser_en,
  output logic                 o_deser_en,
  output logic                 o_ic_phase,
  output logic                 o_busy,
  output logic                 o_done
);
  localparam int EW = $clog2(2*WIDTH+1);
  localparam logic [EW-1:0] LAST = EW'(2*WIDTH);
  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;
  state_t               state_q;
  logic                 cpol_q, cpha_q;
  logic [DIV_WIDTH-1:0] div_q, cnt_q;
  logic [EW-1:0]        edge_q, edge_d;
  logic                 sclk_q, cs_n_q, ser_q, deser_q, busy_q, done_q, ic_q;
  logic                 half_d, lead_d;
  assign half_d = cnt_q == div_q;
  assign edge_d = edge_q + 1'b1;
  assign lead_d = edge_d[0];
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      div_q   <= '0;
      cnt_q   <= '0;
      edge_q  <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      ser_q   <= 1'b0;
      deser_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ic_q    <= 1'b0;
    end else begin
      ser_q   <= 1'b0;
      deser_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          sclk_q <= i_cpol;
          if (i_start) begin
            cpol_q  <= i_cpol;
            cpha_q  <= i_cpha;
            div_q   <= i_clk_div;
            ic_q    <= i_cpha;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            edge_q  <= '0;
            ser_q   <= ~i_cpha;
            state_q <= SETUP;
          end
        end
        SETUP, XFER: begin
          // odd edges lead, even edges trail; the last trailing edge has no bit left to shift
          if (half_d) begin
            cnt_q   <= '0;
            sclk_q  <= ~sclk_q;
            edge_q  <= edge_d;
            ser_q   <= lead_d ? cpha_q : (~cpha_q && edge_d != LAST);
            deser_q <= lead_d ? ~cpha_q : cpha_q;
            state_q <= edge_d == LAST ? HOLD : XFER;
          end else cnt_q <= cnt_q + 1'b1;
        end
        HOLD: begin
          if (half_d) begin
            sclk_q  <= cpol_q;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else cnt_q <= cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign o_sclk     = sclk_q;
  assign o_cs_n     = cs_n_q;
  assign o_ser_en   = ser_q;
  assign o_deser_en = deser_q;
  assign o_ic_phase = ic_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: table-driven frames checked against a queue of expected
// per-cycle events, plus reset, ignored-start, back-to-back and divider-change sequences.
module tb_spi_master_ctrl;
  localparam int W = 8;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, cpol = 1'b0, cpha = 1'b0;
  logic [7:0] div = 8'd0;
  logic       sclk, cs_n, ser, deser, ic, busy, done;
  spi_master_ctrl #(.WIDTH(W), .DIV_WIDTH(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_cpol(cpol), .i_cpha(cpha),
    .i_clk_div(div), .o_sclk(sclk), .o_cs_n(cs_n), .o_ser_en(ser),
    .o_deser_en(deser), .o_ic_phase(ic), .o_busy(busy), .o_done(done)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    int   c;
    logic ser, deser, done, sclk, cs_n, busy, ic;
  } ev_t;
  ev_t q[$];
  int   n_chk = 0, n_fail = 0, last_done = 0;
  logic mon_en = 1'b0, sclk_p = 1'b0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic void push_frame(int t0, logic pl, logic ph, int dv);
    int  h = dv + 1;
    ev_t e;
    if (!ph) begin
      e = '{t0+1, 1'b1, 1'b0, 1'b0, pl, 1'b0, 1'b1, ph};
      q.push_back(e);
    end
    for (int k = 1; k <= 2*W; k++) begin
      e.c     = t0 + 1 + k*h;
      e.sclk  = (k % 2 == 1) ? ~pl : pl;
      e.ser   = (k % 2 == 1) ? ph : (!ph && k < 2*W);
      e.deser = (k % 2 == 1) ? !ph : ph;
      e.done  = 1'b0;
      e.cs_n  = 1'b0;
      e.busy  = 1'b1;
      e.ic    = ph;
      q.push_back(e);
    end
    e = '{t0 + 1 + (2*W+1)*h, 1'b0, 1'b0, 1'b1, pl, 1'b1, 1'b0, ph};
    q.push_back(e);
  endfunction
  always @(negedge clk) begin
    if (mon_en && (ser || deser || done || (busy && sclk !== sclk_p))) begin
      if (q.size() == 0) chk("spurious_event", {ser, deser, done, sclk}, 4'b0);
      else begin
        ev_t e;
        e = q.pop_front();
        chk("event", {32'(cyc), ser, deser, done, sclk, cs_n, busy, ic},
            {32'(e.c), e.ser, e.deser, e.done, e.sclk, e.cs_n, e.busy, e.ic});
      end
    end
    if (done) last_done <= cyc;
    if (ser && deser) chk("ser_deser_overlap", 1, 0);
    sclk_p <= sclk;
  end
  logic [7:0] miso_data = 8'hA5, sr = 8'h00;
  logic       miso = 1'b0;
  int         bitcnt = 0;
  always @(posedge clk) begin
    if (start && cs_n) begin
      bitcnt <= 0;
      sr     <= 8'h00;
    end else begin
      if (ser) begin
        miso   <= bitcnt < 8 ? miso_data[bitcnt] : 1'b0;
        bitcnt <= bitcnt + 1;
      end
      if (deser) sr <= {miso, sr[7:1]};
    end
  end
  task automatic start_frame(logic pl, logic ph, int dv, output int t0);
    @(negedge clk);
    cpol = pl;
    cpha = ph;
    div  = 8'(dv);
    repeat (2) @(negedge clk);
    start = 1'b1;
    t0    = cyc;
    push_frame(t0, pl, ph, dv);
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_until(int c);
    while (cyc < c) @(negedge clk);
  endtask
  task automatic wait_frame(int t0, int dv);
    wait_until(t0 + 1 + (2*W+1)*(dv+1) + 2);
    chk("queue_drained", q.size(), 0);
    chk("deser_data", sr, 8'hA5);
  endtask
  typedef struct {
    logic pl, ph;
    int   dv;
    int   done_off;
  } vec_t;
  vec_t vecs[6];
  initial begin
    int t0, t1;
    vecs[0] = '{1'b0, 1'b0, 1,   35};
    vecs[1] = '{1'b1, 1'b1, 0,   18};
    vecs[2] = '{1'b0, 1'b1, 2,   52};
    vecs[3] = '{1'b1, 1'b0, 0,   18};
    vecs[4] = '{1'b0, 1'b0, 3,   69};
    vecs[5] = '{1'b1, 1'b1, 255, 4353};
    repeat (3) @(negedge clk);
    chk("reset_outputs", {cs_n, sclk, ser, deser, busy, done, ic}, 7'b1000000);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    foreach (vecs[i]) begin
      start_frame(vecs[i].pl, vecs[i].ph, vecs[i].dv, t0);
      wait_frame(t0, vecs[i].dv);
      chk($sformatf("done_offset_%0d", i), last_done - t0, vecs[i].done_off);
    end
    mon_en = 1'b0;
    start_frame(1'b0, 1'b0, 1, t0);
    q.delete();
    wait_until(t0 + 11);
    chk("edge5_sclk_high", {sclk, cs_n, busy}, 3'b101);
    rst = 1'b1;
    #1;
    chk("async_reset_mid_frame", {cs_n, sclk, ser, deser, busy, done, ic}, 7'b1000000);
    @(negedge clk);
    rst  = 1'b0;
    cpol = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_reset", {cs_n, sclk, busy}, 3'b110);
    mon_en = 1'b1;
    start_frame(1'b0, 1'b0, 1, t0);
    wait_until(t0 + 10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(t0 + 35);
    chk("done_cycle", done, 1'b1);
    start = 1'b1;
    t1    = cyc;
    push_frame(t1, 1'b0, 1'b0, 1);
    @(negedge clk);
    start = 1'b0;
    chk("back_to_back_cs_n", {cs_n, busy}, 2'b01);
    wait_frame(t1, 1);
    chk("one_done_per_frame", last_done - t1, 35);
    start_frame(1'b0, 1'b0, 1, t0);
    wait_until(t0 + 6);
    div  = 8'd3;
    cpol = 1'b1;
    cpha = 1'b1;
    wait_frame(t0, 1);
    chk("div_change_ignored", last_done - t0, 35);
    start_frame(1'b0, 1'b0, 3, t1);
    wait_until(t1 + 5);
    chk("div4_first_edge", {sclk, deser}, 2'b11);
    wait_frame(t1, 3);
    chk("div4_done", last_done - t1, 69);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule
